// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a one-entry skid buffer, synchronous flush,
// occupancy reporting and a saturating downstream-stall counter.
module pipe_stage_skid #(
  parameter int unsigned WIDTH             = 32,
  parameter int unsigned LANES             = 2,
  parameter bit          FLUSH_CLEARS_DATA = 1'b1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic [1:0]               occupancy,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int unsigned DW = LANES * WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [DW-1:0]    r_main;
  logic [DW-1:0]    r_skid;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [1:0]       r_occ;
  logic [CNT_W-1:0] r_stall;

  logic w_in_fire;
  logic w_out_fire;
  logic w_stalled;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_stalled  = r_out_valid & ~out_ready;

  // in_ready is purely a function of registered state, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occ       <= 2'd0;
      r_stall     <= '0;
    end else begin
      if (w_stalled && (r_stall != {CNT_W{1'b1}})) begin
        r_stall <= r_stall + CNT_W'(1);
      end

      if (flush) begin
        r_state     <= ST_EMPTY;
        r_in_ready  <= 1'b1;
        r_out_valid <= 1'b0;
        r_occ       <= 2'd0;
        if (FLUSH_CLEARS_DATA) begin
          r_main <= '0;
          r_skid <= '0;
        end
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_in_fire) begin
              r_state     <= ST_ONE;
              r_main      <= in_data;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b1;
              r_occ       <= 2'd1;
            end
          end
          ST_ONE: begin
            if (w_in_fire && w_out_fire) begin
              r_main <= in_data;
            end else if (w_in_fire) begin
              // Downstream stalled: park the extra beat and close the input.
              r_state    <= ST_FULL;
              r_skid     <= in_data;
              r_in_ready <= 1'b0;
              r_occ      <= 2'd2;
            end else if (w_out_fire) begin
              r_state     <= ST_EMPTY;
              r_out_valid <= 1'b0;
              r_occ       <= 2'd0;
            end
          end
          ST_FULL: begin
            if (w_out_fire) begin
              r_state    <= ST_ONE;
              r_main     <= r_skid;
              r_in_ready <= 1'b1;
              r_occ      <= 2'd1;
            end
          end
          default: begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
          end
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign occupancy = r_occ;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus a randomized run against
// a queue-based model; three instances cover the parameter variants.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 64;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;

  logic          in_ready,  out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  logic          nc_in_ready, nc_out_valid;
  logic [DW-1:0] nc_out_data;
  logic [1:0]    nc_occupancy;
  logic [15:0]   nc_stall_cnt;

  logic          c2_in_ready, c2_out_valid;
  logic [DW-1:0] c2_out_data;
  logic [1:0]    c2_occupancy;
  logic [1:0]    c2_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents, value shown on out_data, stall count.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_last;
  logic [DW-1:0] m_last_nc;
  int unsigned   m_stall;

  pipe_stage_skid u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.FLUSH_CLEARS_DATA(1'b0)) u_nc (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(nc_in_ready), .in_data(in_data),
    .out_valid(nc_out_valid), .out_ready(out_ready), .out_data(nc_out_data),
    .occupancy(nc_occupancy), .stall_cnt(nc_stall_cnt)
  );

  pipe_stage_skid #(.CNT_W(2)) u_c2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(c2_in_ready), .in_data(in_data),
    .out_valid(c2_out_valid), .out_ready(out_ready), .out_data(c2_out_data),
    .occupancy(c2_occupancy), .stall_cnt(c2_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_last    = '0;
    m_last_nc = '0;
    m_stall   = 0;
  endtask

  // One clock edge; the model advances using the inputs presented before the edge.
  task automatic tick();
    int n;
    @(posedge clk);
    n = q.size();
    if (n > 0 && !out_ready && m_stall < 65535) m_stall++;
    if (flush) begin
      q.delete();
      m_last = '0;
    end else begin
      if (n > 0 && out_ready) void'(q.pop_front());
      if (in_valid && n < 2) q.push_back(in_data);
      if (q.size() > 0) begin
        m_last    = q[0];
        m_last_nc = q[0];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    n_checks++; if (out_data !== 64'd0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_streaming();
    logic [DW-1:0] exp;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      exp      = {~32'(k), 32'(k)};
      in_data  = exp;
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid beat %0d got %b want 1", k, out_valid); end
      n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL stream_data beat %0d got %h want %h", k, out_data, exp); end
      n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ beat %0d got %0d want 1", k, occupancy); end
      n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stream_stall beat %0d got %0d want 0", k, stall_cnt); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_drain got %0d want 0", occupancy); end
  endtask

  task automatic test_skid();
    logic [DW-1:0] a, b;
    a = 64'hA5A5_0001_5A5A_1000;
    b = 64'hB6B6_0002_6B6B_2000;
    in_valid = 1'b1; in_data = a; out_ready = 1'b0;
    tick();
    in_data = b;
    tick();
    n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL skid_occ got %0d want 2", occupancy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_in_ready got %b want 0", in_ready); end
    n_checks++; if (out_data !== a) begin n_fail++; $display("FAIL skid_head got %h want %h", out_data, a); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_checks++; if (out_data !== b || out_valid !== 1'b1) begin n_fail++; $display("FAIL skid_second got %h/%b want %h/1", out_data, out_valid, b); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_ready_back got %b want 1", in_ready); end
    tick();
    n_checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_empty got %0d/%b want 0/0", occupancy, out_valid); end
  endtask

  task automatic test_stall_count();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    in_valid = 1'b1; in_data = 64'h0000_0000_0000_0C0C; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    n_checks++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL stall5 got %0d want 5", stall_cnt); end
    n_checks++; if (c2_stall_cnt !== 2'd3) begin n_fail++; $display("FAIL stall_sat5 got %0d want 3", c2_stall_cnt); end
    tick();
    n_checks++; if (stall_cnt !== 16'd6) begin n_fail++; $display("FAIL stall6 got %0d want 6", stall_cnt); end
    n_checks++; if (c2_stall_cnt !== 2'd3) begin n_fail++; $display("FAIL stall_sat6 got %0d want 3", c2_stall_cnt); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (stall_cnt !== 16'd6) begin n_fail++; $display("FAIL stall_hold got %0d want 6", stall_cnt); end
  endtask

  task automatic test_flush();
    logic [DW-1:0] a, b;
    a = 64'h1111_2222_3333_4444;
    b = 64'h5555_6666_7777_8888;
    out_ready = 1'b0; in_valid = 1'b1; in_data = a;
    tick();
    in_data = b;
    tick();
    flush = 1'b1; in_data = 64'hDEAD;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_state got v=%b occ=%0d rdy=%b want 0/0/1", out_valid, occupancy, in_ready); end
    n_checks++; if (out_data !== 64'd0) begin n_fail++; $display("FAIL flush_clear got %h want 0", out_data); end
    n_checks++; if (nc_out_data !== a || nc_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_keep got %h/%b want %h/0", nc_out_data, nc_out_valid, a); end
    n_checks++; if (stall_cnt !== 16'(m_stall)) begin n_fail++; $display("FAIL flush_stall got %0d want %0d", stall_cnt, m_stall); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_data === 64'hDEAD || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak cycle %0d got %h/%b", i, out_data, out_valid); end
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] c;
    c = 64'hCAFE_0000_0000_F00D;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h0101;
    tick();
    in_data = 64'h0202;
    tick();
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      n_fail++; $display("FAIL areset_ctrl got v=%b rdy=%b occ=%0d want 0/1/0", out_valid, in_ready, occupancy); end
    n_checks++; if (out_data !== 64'd0 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL areset_data got %h cnt=%0d want 0/0", out_data, stall_cnt); end
    #2 reset = 1'b0;
    model_reset();
    in_valid = 1'b1; in_data = c; out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== c) begin n_fail++; $display("FAIL areset_first got %h/%b want %h/1", out_data, out_valid, c); end
    in_valid = 1'b0;
    tick();
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL areset_drain got %0d want 0", occupancy); end
  endtask

  task automatic test_random();
    logic [83:0]   got_m, exp_m, got_n, exp_n;
    logic [69:0]   got_c, exp_c;
    logic [DW-1:0] held;
    logic          hold;
    logic [1:0]    sat;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      in_data   = {$urandom, $urandom};
      hold      = (q.size() > 0) && !out_ready && !flush;
      held      = m_last;
      tick();
      sat   = (m_stall > 3) ? 2'd3 : 2'(m_stall);
      exp_m = {q.size() > 0, q.size() < 2, 2'(q.size()), m_last, 16'(m_stall)};
      exp_n = {q.size() > 0, q.size() < 2, 2'(q.size()), m_last_nc, 16'(m_stall)};
      exp_c = {q.size() > 0, q.size() < 2, 2'(q.size()), m_last, sat};
      got_m = {out_valid, in_ready, occupancy, out_data, stall_cnt};
      got_n = {nc_out_valid, nc_in_ready, nc_occupancy, nc_out_data, nc_stall_cnt};
      got_c = {c2_out_valid, c2_in_ready, c2_occupancy, c2_out_data, c2_stall_cnt};
      n_checks++; if (got_m !== exp_m) begin n_fail++; $display("FAIL rand_main cycle %0d got %h want %h", i, got_m, exp_m); end
      n_checks++; if (got_n !== exp_n) begin n_fail++; $display("FAIL rand_noclear cycle %0d got %h want %h", i, got_n, exp_n); end
      n_checks++; if (got_c !== exp_c) begin n_fail++; $display("FAIL rand_cnt2 cycle %0d got %h want %h", i, got_c, exp_c); end
      if (hold) begin
        n_checks++; if (out_data !== held) begin n_fail++; $display("FAIL rand_hold cycle %0d got %h want %h", i, out_data, held); end
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_streaming();
    test_skid();
    test_stall_count();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register for the MIPS datapath that replaces plain enable/flush stage registers with a valid/ready handshake and a one-entry skid buffer. It sits between adjacent pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries LANES packed fields of WIDTH bits each. It breaks the combinational ready path so a downstream stall never reaches upstream logic in the same cycle, and it adds synchronous flush (bubble insertion), an occupancy output and a saturating stall counter.

## Interface
- WIDTH, 32, bits per lane
- LANES, 2, number of packed fields; lane i occupies bits [i*WIDTH +: WIDTH]
- FLUSH_CLEARS_DATA, 1, 1: flush zeroes both data registers; 0: flush only clears valid bits
- CNT_W, 16, stall counter width
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- flush  input  1  synchronous flush; empties the stage
- in_valid  input  1  upstream holds valid data
- in_ready  output  1  stage can accept; registered
- in_data  input  LANES*WIDTH  upstream payload
- out_valid  output  1  out_data is valid; registered
- out_ready  input  1  downstream accepts
- out_data  output  LANES*WIDTH  payload; driven directly from the main register
- occupancy  output  2  entries held: 0, 1 or 2
- stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Storage: main register (feeds out_data) and skid register, each with a valid bit.
- Accept: in_fire = in_valid & in_ready. Release: out_fire = out_valid & out_ready.
- States:
  - EMPTY: occupancy 0, out_valid 0, in_ready 1.
  - ONE: main valid only; out_valid 1, in_ready 1.
  - FULL: main and skid valid; out_valid 1, in_ready 0.
- Transitions when flush=0:
  - EMPTY with in_fire: go to ONE; main <= in_data.
  - ONE with in_fire and out_fire: stay in ONE; main <= in_data.
  - ONE with in_fire only: go to FULL; skid <= in_data.
  - ONE with out_fire only: go to EMPTY.
  - FULL with out_fire: go to ONE; main <= skid.
  - FULL cannot see in_fire, because in_ready is 0.
  - No fire of any kind: hold.
- Ordering and hold rules:
  - Data leaves in strict FIFO order.
  - No payload is lost or duplicated.
  - out_data is stable while out_valid=1 and out_ready=0.
- Flush (priority over all handshakes, below reset):
  - Next state is EMPTY.
  - Any in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as delivered downstream.
  - With FLUSH_CLEARS_DATA=1, both data registers are set to 0; with 0 they hold their values.
- stall_cnt:
  - Increments by 1 each cycle with out_valid=1 and out_ready=0, including a flush cycle.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- occupancy equals the number of set valid bits.

## Timing
- Reset values: out_valid=0, in_ready=1, occupancy=0, out_data=0, skid=0, stall_cnt=0.
- Latency: data accepted at edge N appears with out_valid=1 after edge N, so the stage adds 1 cycle.
- Throughput: 1 transfer per cycle when out_ready is held at 1.
- in_ready is a register output; no combinational path exists from out_ready or in_valid to in_ready.
- After out_ready falls with the stage in ONE, the stage accepts at most one more beat (into skid). in_ready then reads 0 from the next cycle.
- When out_ready rises with the stage in FULL, in_ready returns to 1 one cycle later.
- Flush effect is visible after the edge: out_valid=0, in_ready=1, occupancy=0.
- Reset mid-transfer takes effect immediately and drops any held entries.

## Test plan
- Streaming: LANES=2, WIDTH=32; in_valid=1 and out_ready=1 for 8 cycles with lane0=k, lane1=~k. Required: out_data matches each beat 1 cycle later, occupancy stays 1, stall_cnt=0.
- Skid: in ONE holding A, drop out_ready while B is offered. Required: B accepted, occupancy=2, in_ready=0 next cycle. After out_ready=1: A then B in consecutive cycles, in_ready=1 the cycle after A leaves.
- Stall count: hold out_ready=0 with out_valid=1 for 5 cycles. Required: stall_cnt=5. With CNT_W=2 and 6 stall cycles: stall_cnt saturates at 3.
- Flush in FULL with in_valid=1 and data 0xDEAD. Required: next cycle out_valid=0, occupancy=0, out_data=0 (FLUSH_CLEARS_DATA=1), and 0xDEAD never appears at the output. With FLUSH_CLEARS_DATA=0: out_data retains its prior value.
- Asynchronous reset asserted mid-cycle in FULL. Required: outputs take reset values before the next clock edge. First beat after release is accepted and appears 1 cycle later.
- Random: random in_valid/out_ready for 10k cycles checked against a scoreboard. Required: exact in-order delivery, and out_data never changes while out_valid=1 and out_ready=0.
